seq_arith_8b_diff_decoder: RTL and testbench
============================================

Name: seq_arith_8b_diff_decoder

Overview:
Inverse of the team's 8-bit sequential accumulator. The block receives a stream of running sums and recovers the original increments: out[n] = in_[n] - in_[n-1] mod 2^nbits, with the previous sum taken as 0 after reset. It sits on the receive side of an accumulated-sum link. It uses val/rdy handshakes on both ends and has a 2-entry output buffer, so producer and consumer can stall independently.

Parameters:
nbits, 8, data width of sums and recovered increments

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
in_  input  nbits  running-sum sample
in_val  input  1  in_ is valid this cycle
in_rdy  output  1  block can accept a sample this cycle
out  output  nbits  recovered increment (head of output buffer)
out_val  output  1  out is valid this cycle
out_rdy  input  1  consumer accepts out this cycle

Behaviour:
- One clock (clk); reset is synchronous and active-high, sampled on the rising edge of clk.
- State:
  - prev_sum register (nbits)
  - 2-entry FIFO of nbits increments
  - occupancy count: EMPTY=0, ONE=1, FULL=2; this is the block's only FSM.
- Reset, effective at the edge where reset=1:
  - prev_sum=0, count=EMPTY, FIFO pointers=0.
  - Outputs after reset: out_val=0, in_rdy=1, out=0.
- Input transfer occurs when in_val && in_rdy at a rising edge. On transfer:
  - Push (in_ - prev_sum) mod 2^nbits into the FIFO tail.
  - prev_sum <= in_.
- Arithmetic: wrap-around subtraction, no saturation, no overflow flag. Example: prev 0xF0, in_ 0x0F gives 0x1F.
- prev_sum changes only on an input transfer. It holds when in_val=0 or in_rdy=0.
- Output transfer occurs when out_val && out_rdy at a rising edge; it pops the FIFO head.
- out_val = (count != EMPTY). out = FIFO head; out = 0 when EMPTY.
- in_rdy = (count != FULL), registered-state only. It has no combinational path from out_rdy, and there is no bypass when FULL.
- Latency: a sample accepted at edge k appears on out/out_val after edge k (one cycle). There is no same-cycle in-to-out path.
- Simultaneous push and pop:
  - In state ONE: count stays ONE, head advances, new entry written.
  - In state EMPTY: only a push is possible.
  - In state FULL: only a pop is possible, because in_rdy=0.
- Count transitions:
  - EMPTY -> ONE on push.
  - ONE -> FULL on push without pop.
  - ONE -> EMPTY on pop without push.
  - FULL -> ONE on pop.
- Reset mid-operation: buffered entries are discarded and prev_sum returns to 0, regardless of in_val/out_rdy that cycle.
- in_ and out_rdy are don't-care while reset=1.
- Outputs must never be X after the first reset edge.

Decomposition:
- Shared package seq_arith_pkg:
  - localparam default width (8).
  - typedef for the nbits data word.
  - enum for count states EMPTY/ONE/FULL.
- One natural sub-module: seq_arith_2entry_queue. It is the 2-entry FIFO with val/rdy on both sides, count-based state and no bypass.
- The top module holds prev_sum and the subtractor, and wires the handshake through the queue.

Test Plan:
1. Basic decode, out_rdy=1 always: in_ 00,01,03,07,0B,0B with in_val=1 -> out 00,01,02,04,04,00, each one cycle after its input.
2. Wrap-around, out_rdy=1: in_ 00,F0,FF,00,00 -> out 00,F0,0F,01,00.
3. Backpressure, out_rdy=0, in_val=1, in_ 10,30,70:
   - First two samples accepted; in_rdy=0 in the third cycle.
   - Raise out_rdy -> out 10 then 20.
   - in_rdy returns to 1; 70 accepted -> out 40.
   - prev_sum unaffected by the stalled cycles.
4. Reset mid-operation:
   - Feed 01,03, hold out_rdy=0, then reset=1 for 3 cycles -> out_val=0, in_rdy=1.
   - Then feed 01,03,07 with out_rdy=1 -> out 01,02,04. This confirms buffered entries were dropped and prev_sum=0.
5. Input bubbles: in_ 05 (val=1), 99 (val=0), 08 (val=1) -> out 05,03. The invalid 99 does not update prev_sum.
6. Random, 20 cycles: random in_/in_val/out_rdy, with reset asserted ~10% of cycles.
   - Scoreboard models prev_sum and the 2-deep queue.
   - Every out transfer must equal the model's difference.
   - in_rdy must equal (count != 2) every cycle.

Source files
------------

// File: rtl/seq_arith_pkg.sv
// rtl/seq_arith_pkg.sv - shared types for the sequential-arithmetic blocks
// Purpose: default data width, data word type and the output-queue
//          occupancy states used by the diff decoder and its queue.
// Ports:   none (package).
package seq_arith_pkg;

  localparam int NBITS_DEFAULT = 8;

  typedef logic [NBITS_DEFAULT-1:0] word_t;

  // Queue occupancy doubles as the block's only FSM state.
  typedef enum logic [1:0] {
    CNT_EMPTY = 2'd0,
    CNT_ONE   = 2'd1,
    CNT_FULL  = 2'd2
  } count_e;

endpackage

// File: rtl/seq_arith_2entry_queue.sv
// rtl/seq_arith_2entry_queue.sv - 2-entry val/rdy FIFO with count-based state
// Purpose: buffers up to two words so producer and consumer stall independently.
//          enq_rdy and deq_val are registered from the next occupancy, so there
//          is no combinational path between the two sides and no bypass.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   enq_data/val/rdy    write side handshake
//   deq_data/val/rdy    read side handshake; deq_data is 0 while empty
import seq_arith_pkg::*;

module seq_arith_2entry_queue #(
  parameter int nbits = NBITS_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [nbits-1:0] enq_data,
  input  logic             enq_val,
  output logic             enq_rdy,
  output logic [nbits-1:0] deq_data,
  output logic             deq_val,
  input  logic             deq_rdy
);

  logic [nbits-1:0] mem_q [2];
  logic [nbits-1:0] mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  count_e           count_q, count_d;
  logic             enq_rdy_q, enq_rdy_d;
  logic             deq_val_q, deq_val_d;
  logic             push, pop;

  always_comb begin
    push     = enq_val && enq_rdy_q;
    pop      = deq_val_q && deq_rdy;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push) begin
      mem_d[wr_ptr_q] = enq_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    // Push+pop together leaves the count unchanged (only reachable in ONE).
    case ({push, pop})
      2'b10:   count_d = (count_q == CNT_EMPTY) ? CNT_ONE : CNT_FULL;
      2'b01:   count_d = (count_q == CNT_FULL) ? CNT_ONE : CNT_EMPTY;
      default: count_d = count_q;
    endcase

    enq_rdy_d = (count_d != CNT_FULL);
    deq_val_d = (count_d != CNT_EMPTY);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q[0]  <= '0;
      mem_q[1]  <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= CNT_EMPTY;
      enq_rdy_q <= 1'b1;
      deq_val_q <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      enq_rdy_q <= enq_rdy_d;
      deq_val_q <= deq_val_d;
    end
  end

  assign enq_rdy  = enq_rdy_q;
  assign deq_val  = deq_val_q;
  assign deq_data = deq_val_q ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/seq_arith_8b_diff_decoder.sv
// rtl/seq_arith_8b_diff_decoder.sv - recovers increments from a running-sum stream
// Purpose: out[n] = in_[n] - in_[n-1] (mod 2^nbits), previous sum 0 after reset,
//          with a 2-entry output buffer between the subtractor and the consumer.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_, in_val, in_rdy   running-sum input handshake
//   out, out_val, out_rdy recovered-increment output handshake
import seq_arith_pkg::*;

module seq_arith_8b_diff_decoder #(
  parameter int nbits = NBITS_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [nbits-1:0] in_,
  input  logic             in_val,
  output logic             in_rdy,
  output logic [nbits-1:0] out,
  output logic             out_val,
  input  logic             out_rdy
);

  logic [nbits-1:0] prev_sum_q, prev_sum_d;
  logic [nbits-1:0] diff;
  logic             in_xfer;

  always_comb begin
    in_xfer    = in_val && in_rdy;
    diff       = in_ - prev_sum_q;  // wraps modulo 2^nbits
    prev_sum_d = in_xfer ? in_ : prev_sum_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_sum_q <= '0;
    end else begin
      prev_sum_q <= prev_sum_d;
    end
  end

  seq_arith_2entry_queue #(.nbits(nbits)) u_queue (
    .clk      (clk),
    .reset    (reset),
    .enq_data (diff),
    .enq_val  (in_val),
    .enq_rdy  (in_rdy),
    .deq_data (out),
    .deq_val  (out_val),
    .deq_rdy  (out_rdy)
  );

endmodule

// File: tb/tb_seq_arith_8b_diff_decoder.sv
// tb/tb_seq_arith_8b_diff_decoder.sv - self-checking bench for the diff decoder
import seq_arith_pkg::*;

module tb_seq_arith_8b_diff_decoder;

  logic  clk;
  logic  reset;
  word_t in_;
  logic  in_val;
  logic  in_rdy;
  word_t out;
  logic  out_val;
  logic  out_rdy;

  int tests;
  int fails;

  seq_arith_8b_diff_decoder #(.nbits(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .in_     (in_),
    .in_val  (in_val),
    .in_rdy  (in_rdy),
    .out     (out),
    .out_val (out_val),
    .out_rdy (out_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs are applied at a falling edge, one rising edge passes, and the
  // task returns at the next falling edge where outputs are sampled.
  task automatic drive(input logic [7:0] d, input logic v, input logic r);
    in_     = d;
    in_val  = v;
    out_rdy = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) drive(8'h00, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  logic [7:0] t1_in  [6];
  logic [7:0] t1_out [6];
  logic [7:0] t2_in  [5];
  logic [7:0] t2_out [5];

  // Scoreboard state for the random phase
  logic [7:0] m_prev;
  logic [7:0] m_q [2];
  int         m_cnt;
  logic [7:0] r_in;
  logic       r_val, r_rdy, r_rst;
  logic       m_push, m_pop;

  initial begin
    tests   = 0;
    fails   = 0;
    reset   = 1'b1;
    in_     = 8'h00;
    in_val  = 1'b0;
    out_rdy = 1'b0;
    @(negedge clk);

    // Reset state
    do_reset(2);
    chk("rst_out_val", {31'd0, out_val}, 32'd0);
    chk("rst_in_rdy",  {31'd0, in_rdy},  32'd1);
    chk("rst_out",     {24'd0, out},     32'd0);

    // 1: basic decode
    t1_in  = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0B, 8'h0B};
    t1_out = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h04, 8'h00};
    for (int i = 0; i < 6; i++) begin
      drive(t1_in[i], 1'b1, 1'b1);
      chk("t1_out_val", {31'd0, out_val}, 32'd1);
      chk("t1_out",     {24'd0, out},     {24'd0, t1_out[i]});
      chk("t1_in_rdy",  {31'd0, in_rdy},  32'd1);
    end
    drive(8'h00, 1'b0, 1'b1);
    chk("t1_drain", {31'd0, out_val}, 32'd0);

    // 2: wrap-around
    do_reset(1);
    t2_in  = '{8'h00, 8'hF0, 8'hFF, 8'h00, 8'h00};
    t2_out = '{8'h00, 8'hF0, 8'h0F, 8'h01, 8'h00};
    for (int i = 0; i < 5; i++) begin
      drive(t2_in[i], 1'b1, 1'b1);
      chk("t2_out", {24'd0, out}, {24'd0, t2_out[i]});
    end

    // 3: backpressure
    do_reset(1);
    drive(8'h10, 1'b1, 1'b0);
    chk("t3_one_rdy", {31'd0, in_rdy}, 32'd1);
    chk("t3_one_out", {24'd0, out},    32'h10);
    drive(8'h30, 1'b1, 1'b0);
    chk("t3_full_rdy", {31'd0, in_rdy}, 32'd0);
    drive(8'h70, 1'b1, 1'b0);
    chk("t3_stall_rdy", {31'd0, in_rdy},  32'd0);
    chk("t3_stall_val", {31'd0, out_val}, 32'd1);
    chk("t3_head_10",   {24'd0, out},     32'h10);
    drive(8'h70, 1'b1, 1'b1);
    chk("t3_head_20",   {24'd0, out},     32'h20);
    chk("t3_rdy_back",  {31'd0, in_rdy},  32'd1);
    drive(8'h70, 1'b1, 1'b1);
    chk("t3_head_40",   {24'd0, out},     32'h40);
    drive(8'h00, 1'b0, 1'b1);
    chk("t3_drain",     {31'd0, out_val}, 32'd0);

    // 4: reset mid-operation
    do_reset(1);
    drive(8'h01, 1'b1, 1'b0);
    drive(8'h03, 1'b1, 1'b0);
    chk("t4_full", {31'd0, in_rdy}, 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) drive(8'hA5, 1'b1, 1'b1);
    reset = 1'b0;
    chk("t4_out_val", {31'd0, out_val}, 32'd0);
    chk("t4_in_rdy",  {31'd0, in_rdy},  32'd1);
    chk("t4_out",     {24'd0, out},     32'd0);
    drive(8'h01, 1'b1, 1'b1);
    chk("t4_a", {24'd0, out}, 32'h01);
    drive(8'h03, 1'b1, 1'b1);
    chk("t4_b", {24'd0, out}, 32'h02);
    drive(8'h07, 1'b1, 1'b1);
    chk("t4_c", {24'd0, out}, 32'h04);

    // 5: input bubbles
    do_reset(1);
    drive(8'h05, 1'b1, 1'b1);
    chk("t5_a",      {24'd0, out},     32'h05);
    drive(8'h99, 1'b0, 1'b1);
    chk("t5_bubble", {31'd0, out_val}, 32'd0);
    drive(8'h08, 1'b1, 1'b1);
    chk("t5_b",      {24'd0, out},     32'h03);

    // 6: random with scoreboard
    do_reset(1);
    m_prev = 8'h00;
    m_cnt  = 0;
    m_q[0] = 8'h00;
    m_q[1] = 8'h00;
    for (int c = 0; c < 20; c++) begin
      chk("t6_in_rdy",  {31'd0, in_rdy},  {31'd0, (m_cnt != 2)});
      chk("t6_out_val", {31'd0, out_val}, {31'd0, (m_cnt != 0)});
      if (m_cnt != 0) chk("t6_out", {24'd0, out}, {24'd0, m_q[0]});
      r_in  = 8'($urandom);
      r_val = 1'($urandom_range(1));
      r_rdy = 1'($urandom_range(1));
      r_rst = ($urandom_range(9) == 0);
      m_push = r_val && (m_cnt != 2);
      m_pop  = r_rdy && (m_cnt != 0);
      if (r_rst) begin
        m_cnt  = 0;
        m_prev = 8'h00;
      end else begin
        if (m_pop) begin
          m_q[0] = m_q[1];
          m_cnt  = m_cnt - 1;
        end
        if (m_push) begin
          m_q[m_cnt] = r_in - m_prev;
          m_cnt      = m_cnt + 1;
          m_prev     = r_in;
        end
      end
      reset = r_rst;
      drive(r_in, r_val, r_rdy);
      reset = 1'b0;
    end
    chk("t6_end_rdy", {31'd0, in_rdy},  {31'd0, (m_cnt != 2)});
    chk("t6_end_val", {31'd0, out_val}, {31'd0, (m_cnt != 0)});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
